// File: rtl/sig_playback.sv
// rtl/sig_playback.sv - replays a stored level/duration word sequence onto sigOut
//
// Purpose:
//   Walks a signal-storage memory one word at a time and drives sigOut with
//   each word's level for that word's hold duration. Each word is:
//   [31] level, [30] last-word flag, [29:0] hold duration.
//   The storage owns its address pointer. This block only asks it to rewind
//   or advance, using one-cycle pulses.
//   A pass ends at the word that has the last flag set. The sequence then
//   repeats loopCount times. A loopCount of 0 repeats until stop.
//
// Ports:
//   clk, reset        sole clock; asynchronous active-high reset
//   start             level; accepted only while idle (stop must be low)
//   stop              level; aborts playback from any busy state
//   loopCount         number of passes, captured when start is accepted
//   memData           word currently presented by storage
//   returnToBaseAddr  one-cycle pulse: storage pointer back to base
//   incrementAddr     one-cycle pulse: storage pointer forward by one
//   sigOut            played-back signal
//   busy              high whenever not idle
//   done              one-cycle pulse on normal completion
//   loopDBG           completed-pass counter

module sig_playback #(
    parameter int SETTLE = 3,
    parameter int LOOP_W = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              stop,
    input  logic [LOOP_W-1:0] loopCount,
    input  logic [31:0]       memData,
    output logic              returnToBaseAddr,
    output logic              incrementAddr,
    output logic              sigOut,
    output logic              busy,
    output logic              done,
    output logic [LOOP_W-1:0] loopDBG
);

    localparam int SCNT_W = (SETTLE > 1) ? $clog2(SETTLE) : 1;
    localparam logic [SCNT_W-1:0] SCNT_LAST = SCNT_W'(SETTLE - 1);

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_REWIND  = 3'd1,
        ST_SETTLE  = 3'd2,
        ST_LOAD    = 3'd3,
        ST_HOLD    = 3'd4,
        ST_ADVANCE = 3'd5,
        ST_FINISH  = 3'd6
    } state_t;

    state_t              state_q,      state_d;
    logic [SCNT_W-1:0]   settle_cnt_q, settle_cnt_d;
    logic [29:0]         hold_cnt_q,   hold_cnt_d;
    logic                last_q,       last_d;
    logic [LOOP_W-1:0]   loop_max_q,   loop_max_d;
    logic [LOOP_W-1:0]   loop_cnt_q,   loop_cnt_d;
    logic                sig_q,        sig_d;
    logic                busy_q,       busy_d;
    logic                done_q,       done_d;
    logic                inc_q,        inc_d;
    logic                ret_q,        ret_d;

    // Pass count after the current pass completes. It saturates at all-ones,
    // so an infinite run can never wrap the debug counter back to zero.
    logic [LOOP_W-1:0]   loop_inc;

    always_comb begin
        state_d      = state_q;
        settle_cnt_d = settle_cnt_q;
        hold_cnt_d   = hold_cnt_q;
        last_d       = last_q;
        loop_max_d   = loop_max_q;
        loop_cnt_d   = loop_cnt_q;
        sig_d        = sig_q;
        loop_inc     = (&loop_cnt_q) ? loop_cnt_q : loop_cnt_q + 1'b1;

        case (state_q)
            ST_IDLE: begin
                if (start && !stop) begin
                    state_d    = ST_REWIND;
                    loop_max_d = loopCount;
                    loop_cnt_d = '0;
                end
            end
            ST_REWIND: begin
                state_d      = ST_SETTLE;
                settle_cnt_d = '0;
            end
            ST_SETTLE: begin
                // Storage needs time to move its pointer and read the word.
                // memData is not trusted until this count runs out.
                if (settle_cnt_q == SCNT_LAST) begin
                    state_d = ST_LOAD;
                end else begin
                    settle_cnt_d = settle_cnt_q + 1'b1;
                end
            end
            ST_LOAD: begin
                sig_d  = memData[31];
                last_d = memData[30];
                // A zero duration still holds for one cycle. This keeps the
                // per-word period at a minimum of SETTLE + 3.
                hold_cnt_d = (memData[29:0] == 30'd0) ? 30'd1 : memData[29:0];
                state_d    = ST_HOLD;
            end
            ST_HOLD: begin
                if (hold_cnt_q == 30'd1) begin
                    if (last_q) begin
                        loop_cnt_d = loop_inc;
                        if ((loop_max_q == '0) || (loop_inc < loop_max_q)) begin
                            state_d = ST_REWIND;
                        end else begin
                            state_d = ST_FINISH;
                        end
                    end else begin
                        state_d = ST_ADVANCE;
                    end
                end else begin
                    hold_cnt_d = hold_cnt_q - 30'd1;
                end
            end
            ST_ADVANCE: begin
                state_d      = ST_SETTLE;
                settle_cnt_d = '0;
            end
            ST_FINISH: begin
                state_d = ST_IDLE;
                sig_d   = 1'b0;
            end
            default: begin
                state_d = ST_IDLE;
                sig_d   = 1'b0;
            end
        endcase

        // stop overrides everything the state decode chose. That includes a
        // pass-end increment and any rewind/advance that was about to start.
        if (stop && (state_q != ST_IDLE)) begin
            state_d    = ST_IDLE;
            sig_d      = 1'b0;
            loop_cnt_d = loop_cnt_q;
        end

        // The outputs are registered decodes of the state being entered.
        // Each pulse is therefore high for exactly the one cycle that is
        // spent in its state.
        busy_d = (state_d != ST_IDLE);
        ret_d  = (state_d == ST_REWIND);
        inc_d  = (state_d == ST_ADVANCE);
        done_d = (state_d == ST_FINISH);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= ST_IDLE;
            settle_cnt_q <= '0;
            hold_cnt_q   <= '0;
            last_q       <= 1'b0;
            loop_max_q   <= '0;
            loop_cnt_q   <= '0;
            sig_q        <= 1'b0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            inc_q        <= 1'b0;
            ret_q        <= 1'b0;
        end else begin
            state_q      <= state_d;
            settle_cnt_q <= settle_cnt_d;
            hold_cnt_q   <= hold_cnt_d;
            last_q       <= last_d;
            loop_max_q   <= loop_max_d;
            loop_cnt_q   <= loop_cnt_d;
            sig_q        <= sig_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
            inc_q        <= inc_d;
            ret_q        <= ret_d;
        end
    end

    assign returnToBaseAddr = ret_q;
    assign incrementAddr    = inc_q;
    assign sigOut           = sig_q;
    assign busy             = busy_q;
    assign done             = done_q;
    assign loopDBG          = loop_cnt_q;

endmodule

// File: tb/tb_sig_playback.sv
// tb/tb_sig_playback.sv - self-checking bench for sig_playback

module tb_sig_playback;

    localparam int SETTLE = 3;
    localparam int LOOP_W = 16;

    logic              clk = 1'b0;
    logic              reset = 1'b1;
    logic              start = 1'b0;
    logic              stop = 1'b0;
    logic [LOOP_W-1:0] loop_count = '0;
    logic [31:0]       mem_data = '0;
    logic              ret_pulse, inc_pulse, sig_out, busy, done;
    logic [LOOP_W-1:0] loop_dbg;

    sig_playback #(.SETTLE(SETTLE), .LOOP_W(LOOP_W)) dut (
        .clk(clk),
        .reset(reset),
        .start(start),
        .stop(stop),
        .loopCount(loop_count),
        .memData(mem_data),
        .returnToBaseAddr(ret_pulse),
        .incrementAddr(inc_pulse),
        .sigOut(sig_out),
        .busy(busy),
        .done(done),
        .loopDBG(loop_dbg)
    );

    always #5 clk = ~clk;

    // Storage model: the pointer moves on a pulse, and the read has one
    // cycle of latency.
    logic [31:0] words [0:7];
    int          ptr = 0;
    always @(posedge clk) begin
        if (ret_pulse)      ptr <= 0;
        else if (inc_pulse) ptr <= ptr + 1;
        mem_data <= words[ptr[2:0]];
    end

    function automatic logic [31:0] mk_word(input logic lvl, input logic last, input int dur);
        return {lvl, last, 30'(dur)};
    endfunction

    typedef struct packed {
        logic              sig;
        logic              busy;
        logic              ret;
        logic              inc;
        logic              done;
        logic [LOOP_W-1:0] lc;
    } exp_t;

    exp_t              exp_q[$];
    logic [LOOP_W-1:0] idle_lc = '0;
    int checks = 0, failures = 0, cyc = 0;
    int n_ret = 0, n_inc = 0, n_done = 0, n_high = 0, gap = 0;
    bit seen_pulse = 1'b0;

    task automatic push(input logic s, input logic b, input logic r, input logic i,
                        input logic d, input logic [LOOP_W-1:0] lc);
        exp_t e;
        e.sig = s; e.busy = b; e.ret = r; e.inc = i; e.done = d; e.lc = lc;
        exp_q.push_back(e);
    endtask

    // Expected timeline of one accepted start, one entry per cycle. The
    // first entry is the idle cycle in which start is presented.
    task automatic build_run(input int lcount, input int max_passes);
        logic [LOOP_W-1:0] loops;
        logic s;
        int w, d, passes;
        loops = (exp_q.size() == 0) ? idle_lc : exp_q[$].lc;
        s = 1'b0;
        push(0, 0, 0, 0, 0, loops);
        loops = '0;
        passes = 0;
        forever begin
            push(s, 1, 1, 0, 0, loops);                  // rewind
            w = 0;
            forever begin
                repeat (SETTLE) push(s, 1, 0, 0, 0, loops);
                push(s, 1, 0, 0, 0, loops);              // load cycle
                s = words[w][31];
                d = (words[w][29:0] == 30'd0) ? 1 : int'(words[w][29:0]);
                repeat (d) push(s, 1, 0, 0, 0, loops);   // hold
                if (words[w][30]) break;
                push(s, 1, 0, 1, 0, loops);              // advance
                w++;
            end
            if (loops != '1) loops = loops + 1'b1;
            passes++;
            if (lcount != 0 && int'(loops) >= lcount) begin
                push(s, 1, 0, 0, 1, loops);              // finish
                return;
            end
            if (passes >= max_passes) return;
        end
    endtask

    exp_t              cmp_e;
    logic [LOOP_W+4:0] cmp_act;
    always @(negedge clk) begin
        cyc++;
        if (exp_q.size() > 0) begin
            cmp_e   = exp_q.pop_front();
            idle_lc = cmp_e.lc;
        end else begin
            cmp_e    = '0;
            cmp_e.lc = idle_lc;
        end
        cmp_act = {sig_out, busy, ret_pulse, inc_pulse, done, loop_dbg};
        checks++;
        if (cmp_act !== cmp_e) begin
            failures++;
            $display("FAIL outputs cyc=%0d got=%b required=%b (sig,busy,ret,inc,done,loopDBG)",
                     cyc, cmp_act, cmp_e);
        end
        if (reset) begin
            seen_pulse = 1'b0;
            gap = 0;
        end else begin
            if (ret_pulse || inc_pulse) begin
                checks++;
                if ((ret_pulse && inc_pulse) || (seen_pulse && gap < SETTLE)) begin
                    failures++;
                    $display("FAIL pulse_rule cyc=%0d ret=%b inc=%b gap=%0d required gap>=%0d",
                             cyc, ret_pulse, inc_pulse, gap, SETTLE);
                end
                seen_pulse = 1'b1;
                gap = 0;
            end else begin
                gap++;
            end
            if (ret_pulse) n_ret++;
            if (inc_pulse) n_inc++;
            if (done)      n_done++;
            if (sig_out)   n_high++;
        end
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic lit(input string name, input longint got, input longint want);
        checks++;
        if (got != want) begin
            failures++;
            $display("FAIL %s got=%0d required=%0d", name, got, want);
        end
    endtask

    task automatic wait_drain(input int budget, input string name);
        int k;
        k = 0;
        while (exp_q.size() != 0 && k < budget) begin
            tick(1);
            k++;
        end
        checks++;
        if (exp_q.size() != 0) begin
            failures++;
            $display("FAIL %s timeout left=%0d required=0", name, exp_q.size());
            exp_q.delete();
        end
        tick(2);
    endtask

    task automatic abort_with_stop();
        exp_t keep;
        if (exp_q.size() > 0) begin
            keep = exp_q[0];
            exp_q.delete();
            exp_q.push_back(keep);
        end
        stop = 1'b1;
        tick(1);
        stop = 1'b0;
    endtask

    int b_ret, b_inc, b_done, b_high;
    task automatic snap();
        b_ret = n_ret; b_inc = n_inc; b_done = n_done; b_high = n_high;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int i = 0; i < 8; i++) words[i] = mk_word(1'b0, 1'b1, 1);
        tick(3);
        lit("reset_busy", busy, 0);
        lit("reset_sig", sig_out, 0);
        lit("reset_loopdbg", loop_dbg, 0);
        reset = 1'b0;
        tick(2);

        // Single pass with start held high while busy (ignored).
        words[0] = mk_word(1'b1, 1'b0, 4);
        words[1] = mk_word(1'b0, 1'b1, 2);
        loop_count = 16'd1;
        snap();
        build_run(1, 1);
        start = 1'b1;
        tick(3);
        start = 1'b0;
        wait_drain(200, "single_pass");
        lit("single_ret", n_ret - b_ret, 1);
        lit("single_inc", n_inc - b_inc, 1);
        lit("single_done", n_done - b_done, 1);
        lit("single_high", n_high - b_high, 9);
        lit("single_busy_after", busy, 0);

        // Three passes.
        loop_count = 16'd3;
        snap();
        build_run(3, 3);
        start = 1'b1;
        tick(1);
        start = 1'b0;
        wait_drain(300, "loop3");
        lit("loop3_ret", n_ret - b_ret, 3);
        lit("loop3_inc", n_inc - b_inc, 3);
        lit("loop3_done", n_done - b_done, 1);
        lit("loop3_loopdbg", loop_dbg, 3);

        // Zero duration, two passes of one word.
        words[0] = mk_word(1'b1, 1'b1, 0);
        loop_count = 16'd2;
        snap();
        build_run(2, 2);
        start = 1'b1;
        tick(1);
        start = 1'b0;
        wait_drain(200, "zero_dur");
        lit("zero_high", n_high - b_high, 8);
        lit("zero_inc", n_inc - b_inc, 0);
        lit("zero_done", n_done - b_done, 1);

        // Start held across a finish restarts playback.
        loop_count = 16'd1;
        snap();
        build_run(1, 1);
        build_run(1, 1);
        start = 1'b1;
        tick(10);
        start = 1'b0;
        wait_drain(200, "restart");
        lit("restart_done", n_done - b_done, 2);
        lit("restart_ret", n_ret - b_ret, 2);

        // Infinite loop, then stop.
        words[0] = mk_word(1'b1, 1'b0, 4);
        words[1] = mk_word(1'b0, 1'b1, 2);
        loop_count = 16'd0;
        snap();
        build_run(0, 70);
        start = 1'b1;
        tick(1);
        start = 1'b0;
        tick(1000);
        lit("inf_still_busy", busy, 1);
        abort_with_stop();
        lit("inf_stop_busy", busy, 0);
        lit("inf_stop_sig", sig_out, 0);
        lit("inf_done", n_done - b_done, 0);
        tick(2);

        // stop has priority over start while idle.
        start = 1'b1;
        stop = 1'b1;
        tick(2);
        start = 1'b0;
        stop = 1'b0;
        lit("stop_prio_busy", busy, 0);
        tick(1);

        // Stop during SETTLE, then asynchronous reset during HOLD.
        loop_count = 16'd1;
        snap();
        build_run(1, 1);
        start = 1'b1;
        tick(1);
        start = 1'b0;
        tick(2);
        abort_with_stop();
        lit("stop_settle_busy", busy, 0);
        build_run(1, 1);
        start = 1'b1;
        tick(1);
        start = 1'b0;
        tick(6);
        lit("pre_reset_hold_sig", sig_out, 1);
        reset = 1'b1;
        exp_q.delete();
        idle_lc = '0;
        #1;
        lit("areset_sig", sig_out, 0);
        lit("areset_busy", busy, 0);
        lit("areset_ret", ret_pulse, 0);
        lit("areset_inc", inc_pulse, 0);
        lit("areset_loopdbg", loop_dbg, 0);
        tick(2);
        reset = 1'b0;
        tick(3);
        lit("abort_done", n_done - b_done, 0);
        lit("abort_ret", n_ret - b_ret, 2);
        lit("abort_inc", n_inc - b_inc, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
